// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - sequences a host bitstream into a daisy chain of CLB config frames
module cfg_chain_loader #(
   parameter int FRAME_LEN = 153,
   parameter int NUM_TILES = 4,
   parameter int GAP       = 2,
   parameter int TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        crst_n,
   input  logic        cfg_go,
   input  logic        cfg_abort,
   input  logic [31:0] wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic        cfg_in_start,
   output logic        cfg_bit_in,
   input  logic        cfg_out_start,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        fabric_rst,
   output logic        fabric_ce
);

   localparam int TOT_BITS  = NUM_TILES * FRAME_LEN;
   localparam int NUM_WORDS = (TOT_BITS + 31) / 32;
   localparam int FCW = $clog2(NUM_TILES + 1);
   localparam int BCW = $clog2(FRAME_LEN + 1);
   localparam int GCW = $clog2(GAP + 2);
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam int WCW = $clog2(NUM_WORDS + 1);

   localparam logic [FCW-1:0] LAST_FRAME = FCW'(NUM_TILES - 1);
   localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_LEN - 1);
   localparam logic [GCW-1:0] GAP_LAST   = GCW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT - 1);
   localparam logic [WCW-1:0] WORDS_MAX  = WCW'(NUM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SHIFT, S_GAP, S_WAIT, S_DONE, S_ERR
   } state_t;

   state_t state, state_nx;

   logic [31:0]    wbuf;
   logic [5:0]     wcnt;
   logic [WCW-1:0] words_in;
   logic [FCW-1:0] frame_cnt;
   logic [BCW-1:0] bit_cnt;
   logic [GCW-1:0] gap_cnt;
   logic [TCW-1:0] to_cnt;

   logic       in_busy, go_ok, abort_ok, xfer, pop, pop_bit, underrun, frame_end;
   logic [1:0] fail_code;

   logic       start_nx, bit_nx, busy_nx, done_nx, err_nx, frst_nx, fce_nx;
   logic [1:0] code_nx;

   assign in_busy  = (state == S_FETCH) || (state == S_SHIFT) ||
                     (state == S_GAP)   || (state == S_WAIT);
   assign go_ok    = cfg_go && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign abort_ok = cfg_abort && in_busy;

   // A new word is taken only when the buffer is empty or its last bit leaves this cycle.
   assign wr_ready = ((state == S_FETCH) || (state == S_SHIFT) || (state == S_GAP)) &&
                     (words_in < WORDS_MAX) &&
                     ((wcnt == 6'd0) || ((wcnt == 6'd1) && (state == S_SHIFT)));
   assign xfer     = wr_valid && wr_ready;

   // With an empty buffer the incoming word's bit 0 is shifted straight through.
   assign pop       = (state == S_SHIFT) && ((wcnt != 6'd0) || xfer) && !abort_ok;
   assign pop_bit   = (wcnt == 6'd0) ? wr_data[0] : wbuf[0];
   assign underrun  = (state == S_SHIFT) && (wcnt == 6'd0) && !xfer;
   assign frame_end = pop && (bit_cnt == LAST_BIT);

   // State register
   always_ff @(posedge clk or negedge crst_n) begin
      if (!crst_n) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next-state selection; abort outranks every other exit from a busy state
   always_comb begin
      state_nx  = state;
      fail_code = 2'd0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (go_ok) state_nx = S_FETCH;
         end
         S_FETCH: begin
            if (abort_ok)  begin state_nx = S_ERR; fail_code = 2'd3; end
            else if (xfer) state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            if (abort_ok)      begin state_nx = S_ERR; fail_code = 2'd3; end
            else if (underrun) begin state_nx = S_ERR; fail_code = 2'd1; end
            else if (frame_end) begin
               if (frame_cnt == LAST_FRAME) state_nx = S_WAIT;
               else if (GAP == 0)           state_nx = S_SHIFT;
               else                         state_nx = S_GAP;
            end
         end
         S_GAP: begin
            if (abort_ok)                 begin state_nx = S_ERR; fail_code = 2'd3; end
            else if (gap_cnt == GAP_LAST) state_nx = S_SHIFT;
         end
         S_WAIT: begin
            if (abort_ok)                begin state_nx = S_ERR; fail_code = 2'd3; end
            else if (cfg_out_start)      state_nx = S_DONE;
            else if (to_cnt == TO_LAST)  begin state_nx = S_ERR; fail_code = 2'd2; end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Word buffer, frame/bit/gap/timeout counters
   always_ff @(posedge clk or negedge crst_n) begin
      if (!crst_n) begin
         wbuf      <= '0;
         wcnt      <= '0;
         words_in  <= '0;
         frame_cnt <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         to_cnt    <= '0;
      end else if (go_ok) begin
         wbuf      <= '0;
         wcnt      <= '0;
         words_in  <= '0;
         frame_cnt <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         to_cnt    <= '0;
      end else begin
         if (xfer) words_in <= words_in + WCW'(1);
         if (abort_ok) begin
            wcnt <= '0;
         end else if (xfer) begin
            if (pop && (wcnt == 6'd0)) begin
               wbuf <= {1'b0, wr_data[31:1]};
               wcnt <= 6'd31;
            end else begin
               wbuf <= wr_data;
               wcnt <= 6'd32;
            end
         end else if (pop) begin
            wbuf <= {1'b0, wbuf[31:1]};
            wcnt <= wcnt - 6'd1;
         end
         if (pop) begin
            if (bit_cnt == LAST_BIT) begin
               bit_cnt   <= '0;
               frame_cnt <= frame_cnt + FCW'(1);
            end else begin
               bit_cnt <= bit_cnt + BCW'(1);
            end
         end
         gap_cnt <= (state == S_GAP)  ? gap_cnt + GCW'(1) : '0;
         to_cnt  <= (state == S_WAIT) ? to_cnt + TCW'(1)  : '0;
      end
   end

   // Next values of the registered outputs; fabric release lags DONE entry by one cycle
   always_comb begin
      start_nx = pop && (bit_cnt == '0);
      bit_nx   = pop && pop_bit;
      busy_nx  = (state_nx == S_FETCH) || (state_nx == S_SHIFT) ||
                 (state_nx == S_GAP)   || (state_nx == S_WAIT);
      done_nx  = done;
      err_nx   = err;
      code_nx  = err_code;
      frst_nx  = fabric_rst;
      fce_nx   = fabric_ce;
      if (go_ok) begin
         done_nx = 1'b0;
         err_nx  = 1'b0;
         code_nx = 2'd0;
         frst_nx = 1'b1;
         fce_nx  = 1'b0;
      end else begin
         if ((state_nx == S_ERR) && (state != S_ERR)) begin
            err_nx  = 1'b1;
            code_nx = fail_code;
         end
         if ((state_nx == S_DONE) && (state != S_DONE)) done_nx = 1'b1;
         if (state == S_DONE) begin
            frst_nx = 1'b0;
            fce_nx  = 1'b1;
         end
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge crst_n) begin
      if (!crst_n) begin
         cfg_in_start <= 1'b0;
         cfg_bit_in   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= 2'd0;
         fabric_rst   <= 1'b1;
         fabric_ce    <= 1'b0;
      end else begin
         cfg_in_start <= start_nx;
         cfg_bit_in   <= bit_nx;
         busy         <= busy_nx;
         done         <= done_nx;
         err          <= err_nx;
         err_code     <= code_nx;
         fabric_rst   <= frst_nx;
         fabric_ce    <= fce_nx;
      end
   end

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Controller that sequences bitstream loading into a daisy-chained string of CLB config blocks: `cfg_bit_in`/`cfg_in_start` in, `cfg_bit_out`/`cfg_out_start` out of the last tile.
- Accepts 32-bit bitstream words from a host over valid/ready and serializes them LSB-first into NUM_TILES back-to-back frames.
- Confirms completion by waiting for the start echo from the chain end.
- Holds the fabric in reset with CE low until configuration succeeds.

Parameters:
- FRAME_LEN, 153, config bits per tile frame (CLB config size).
- NUM_TILES, 4, tiles in the chain; frames sent farthest tile first.
- GAP, 2, idle cycles between frames (outputs low), 0 allowed.
- TIMEOUT, 1024, max cycles after last frame bit to see `cfg_out_start`.

Ports:
- `clk` input 1: global clock.
- `crst_n` input 1: asynchronous active-low reset.
- `cfg_go` input 1: start pulse; honoured only in IDLE, DONE or ERR.
- `cfg_abort` input 1: abort load; honoured in FETCH/SHIFT/GAP/WAIT.
- `wr_data` input 32: bitstream word, bit 0 shifted first.
- `wr_valid` input 1: host word valid.
- `wr_ready` output 1: loader accepts word (transfer on `wr_valid` && `wr_ready`).
- `cfg_in_start` output 1: high with first bit of each frame.
- `cfg_bit_in` output 1: serial config bit to chain head.
- `cfg_out_start` input 1: start echo from chain tail.
- `busy` output 1: high in FETCH/SHIFT/GAP/WAIT.
- `done` output 1: sticky success, cleared by `cfg_go`.
- `err` output 1: sticky failure, cleared by `cfg_go`.
- `err_code` output 2: 0 none, 1 underrun, 2 timeout, 3 abort.
- `fabric_rst` output 1: active-high reset to CLB `RST`.
- `fabric_ce` output 1: CE to CLBs.

Behaviour:
- States: IDLE, FETCH, SHIFT, GAP, WAIT, DONE, ERR.
- Async reset (`crst_n`=0) forces:
  - state=IDLE;
  - `cfg_in_start`=`cfg_bit_in`=`busy`=`done`=`err`=`fabric_ce`=0;
  - `err_code`=0;
  - `fabric_rst`=1;
  - all counters and the word buffer cleared.
- All outputs except `wr_ready` are registered. `wr_ready` is combinational from state and buffer count.
- `cfg_go` (IDLE/DONE/ERR):
  - Next state FETCH.
  - Clears `done`, `err` and `err_code`.
  - Sets `fabric_rst`=1 and `fabric_ce`=0.
  - Frame counter=0, bit counter=0, buffer empty.
- Total bits TB=NUM_TILES*FRAME_LEN. Words required WN=ceil(TB/32) (default 612 bits, 20 words, last 28 bits padding and discarded).
- Word buffer:
  - 32-bit register plus 6-bit valid-bit count.
  - `wr_ready`=1 when busy, the word count is less than WN, and (count==0, or count==1 with a bit popped this cycle).
  - Frame boundaries do not drain the buffer; bits are packed contiguously across frames.
- FETCH:
  - `wr_ready` high; wait for the first word.
  - On accept → SHIFT.
  - No timeout in FETCH.
- SHIFT:
  - Each cycle pops buffer bit 0 → registered `cfg_bit_in`, visible next cycle.
  - `cfg_in_start` is registered high alongside bit index 0 of each frame, else 0.
  - Exactly FRAME_LEN consecutive bits per frame; no stalls.
- Underrun: a SHIFT cycle with count==0 and no transfer → ERR, `err_code`=1.
- End of frame (bit counter==FRAME_LEN-1 popped):
  - If more frames remain: → GAP for GAP cycles, then SHIFT. With GAP=0, go directly to SHIFT with no idle cycle.
  - Otherwise → WAIT; the timeout counter starts at 0.
  - Word fetch continues during GAP.
- WAIT:
  - `cfg_in_start`=`cfg_bit_in`=0 and `wr_ready`=0.
  - `cfg_out_start`=1 → DONE.
  - Counter reaching TIMEOUT → ERR, `err_code`=2.
  - If `cfg_out_start` arrives in the same cycle the counter reaches TIMEOUT, DONE wins.
- DONE: `done`=1, `fabric_rst`=0, `fabric_ce`=1. Both fabric outputs are registered, so they change one cycle after entry.
- ERR: `err`=1; `fabric_rst` stays 1 and `fabric_ce` stays 0.
- `cfg_abort` (busy states) → ERR, `err_code`=3.
  - Abort beats underrun/timeout/done in the same cycle.
  - Serial outputs go 0 next cycle; buffered bits are dropped.
- `cfg_go` while busy is ignored.
- `cfg_out_start` outside WAIT is ignored.
- Words offered beyond WN are not accepted (`wr_ready`=0).

Test Plan:
- Nominal load: go, 20 words streamed with `wr_valid` always high, echo 5 cycles after last bit.
  - Expect four 153-cycle `cfg_bit_in` bursts separated by 2 idle cycles.
  - Expect `cfg_in_start` high exactly 4 times; bit sequence equals the concatenated words LSB-first.
  - Expect `done`=1 and `fabric_rst` 1→0, `fabric_ce` 0→1.
  - Exactly 20 handshakes.
- Underrun: `wr_valid` dropped for 40 cycles after word 3 → `err`=1, `err_code`=1, `fabric_rst` remains 1, `busy`=0.
- Timeout: never assert `cfg_out_start` → `err_code`=2 exactly TIMEOUT cycles after last frame bit.
- Timeout/echo collision: echo on the timeout cycle → `done`=1, `err`=0.
- Abort mid-frame 2, bit 70 → next cycle `cfg_bit_in`=0, `err_code`=3. Then `cfg_go` with a full load succeeds; the first `cfg_in_start` carries word-0 bit 0.
- Reset mid-SHIFT: `crst_n` low for 1 cycle asynchronously → all outputs at reset values immediately. `cfg_go` while busy and GAP=0 configuration both verified: no idle cycle between frames, start pulses 153 cycles apart.
